// File: rtl/shift_pkg.sv
// Command/state encodings and helpers shared by the shift/rotate engine.
package shift_pkg;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'b000,
      CMD_LOAD = 3'b001,
      CMD_ROR  = 3'b010,
      CMD_ROL  = 3'b011,
      CMD_SRL  = 3'b100,
      CMD_SLL  = 3'b101,
      CMD_SRA  = 3'b110,
      CMD_RSVD = 3'b111
   } cmd_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic logic is_shift(cmd_e c);
      return c inside {CMD_ROR, CMD_ROL, CMD_SRL, CMD_SLL, CMD_SRA};
   endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Command/result bundle for shift_unit; the requester uses master, the engine uses slave.
interface shift_unit_if
   import shift_pkg::*;
#(
   parameter int N = 8
);
   localparam int A = $clog2(N);

   logic         start;
   cmd_e         cmd;
   logic [A-1:0] amt;
   logic [N-1:0] p;
   logic [N-1:0] q;
   logic         sout;
   logic         busy;
   logic         done;
   logic         err;

   modport master (output start, cmd, amt, p, input q, sout, busy, done, err);
   modport slave  (input start, cmd, amt, p, output q, sout, busy, done, err);
endinterface

// File: rtl/shift_step.sv
// One-position shift/rotate step, purely combinational; non-shift commands pass d through.
module shift_step
   import shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] d,
   input  cmd_e         cmd,
   input  logic         fill,
   output logic [N-1:0] d_next,
   output logic         bit_out
);
   always_comb begin
      d_next  = d;
      bit_out = 1'b0;
      case (cmd)
         CMD_ROR: begin d_next = {d[0], d[N-1:1]};   bit_out = d[0];   end
         CMD_ROL: begin d_next = {d[N-2:0], d[N-1]}; bit_out = d[N-1]; end
         CMD_SRL: begin d_next = {1'b0, d[N-1:1]};   bit_out = d[0];   end
         CMD_SLL: begin d_next = {d[N-2:0], 1'b0};   bit_out = d[N-1]; end
         CMD_SRA: begin d_next = {fill, d[N-1:1]};   bit_out = d[0];   end
         default: ;
      endcase
   end
endmodule

// File: rtl/shift_unit.sv
// N-bit load/rotate/shift register with start/busy/done handshake; start is ignored while busy.
// SHIFT_UNIT_BARREL_EN selects the single-cycle barrel engine, otherwise one bit position per clock.
module shift_unit
   import shift_pkg::*;
#(
   parameter  int N = 8,
   localparam int A = $clog2(N)
) (
   input logic         clock,
   input logic         reset,
   shift_unit_if.slave bus
);
   if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("shift_unit: N must be a power of two and at least 4");
   end

   logic [N-1:0] q_r;
   logic         sout_r, done_r, err_r;
   logic         busy, accept;

   assign accept   = bus.start && !busy;
   assign bus.q    = q_r;
   assign bus.sout = sout_r;
   assign bus.busy = busy;
   assign bus.done = done_r;
   assign bus.err  = err_r;

`ifdef SHIFT_UNIT_BARREL_EN
   // stage[k]/sbit[k] hold the register and exit bit after k steps; stage 0 is "no change".
   logic [N-1:0] stage [N];
   logic         sbit  [N];
   logic [A-1:0] sel;

   assign busy     = 1'b0;
   assign sel      = bus.amt;
   assign stage[0] = q_r;
   assign sbit[0]  = sout_r;

   for (genvar i = 0; i < N - 1; i++) begin : g_chain
      shift_step #(.N(N)) u_step (
         .d      (stage[i]),
         .cmd    (bus.cmd),
         .fill   (q_r[N-1]),
         .d_next (stage[i+1]),
         .bit_out(sbit[i+1])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_r    <= '0;
         sout_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         done_r <= accept;
         err_r  <= accept && (bus.cmd == CMD_RSVD);
         if (accept) begin
            if (bus.cmd == CMD_LOAD) begin
               q_r <= bus.p;
            end else if (is_shift(bus.cmd)) begin
               q_r    <= stage[sel];
               sout_r <= sbit[sel];
            end
         end
      end
   end
`else
   state_e       state, state_nx;
   cmd_e         cmd_r, step_cmd;
   logic [A-1:0] cnt;
   logic [N-1:0] step_q;
   logic         step_bit, do_step, long_op;

   // SRA keeps the MSB fixed on every step, so the live MSB is the original sign.
   shift_step #(.N(N)) u_step (
      .d      (q_r),
      .cmd    (step_cmd),
      .fill   (q_r[N-1]),
      .d_next (step_q),
      .bit_out(step_bit)
   );

   assign busy    = (state == SHIFT);
   assign long_op = is_shift(bus.cmd) && (bus.amt > A'(1));

   always_comb begin
      state_nx = state;
      step_cmd = cmd_r;
      do_step  = 1'b0;
      case (state)
         IDLE: begin
            step_cmd = bus.cmd;
            if (accept) begin
               do_step = is_shift(bus.cmd) && (bus.amt != '0);
               if (long_op) state_nx = SHIFT;
            end
         end
         SHIFT: begin
            do_step = 1'b1;
            if (cnt == A'(1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         cmd_r  <= CMD_NOP;
         cnt    <= '0;
         q_r    <= '0;
         sout_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         state  <= state_nx;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         if (do_step) begin
            q_r    <= step_q;
            sout_r <= step_bit;
         end
         if (state == IDLE && accept) begin
            cmd_r  <= bus.cmd;
            cnt    <= bus.amt - A'(1);
            done_r <= !long_op;
            err_r  <= (bus.cmd == CMD_RSVD);
            if (bus.cmd == CMD_LOAD) q_r <= bus.p;
         end
         if (state == SHIFT) begin
            cnt    <= cnt - A'(1);
            done_r <= (cnt == A'(1));
         end
      end
   end
`endif
endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised successor to the team's N-bit rotate register: an N-bit register supporting load, rotate left/right, logical shift left/right and arithmetic shift right, each by a run-time amount, with a start/busy/done handshake. It sits beside the datapath register file as the general shift/rotate engine. A compile-time option selects a serial engine (one bit position per clock) or a single-cycle barrel engine.

## Interface
- `N`, default 8: register width; power of two, ≥ 4 (elaboration-time assertion).
- `A`, default `$clog2(N)`: width of the shift amount; derived, not overridden.
- `clock` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: command request; accepted on a posedge where `start=1` and `busy=0`.
- `cmd` input 3: operation; sampled only at acceptance.
- `amt` input A: shift/rotate amount 0..N-1; sampled only at acceptance.
- `p` input N: load data; sampled only at acceptance.
- `q` output N: register contents.
- `sout` output 1: last bit shifted or rotated out.
- `busy` output 1: multi-cycle operation in progress.
- `done` output 1: one-cycle pulse, operation complete.
- `err` output 1: one-cycle pulse with `done` when the command was reserved.

## Operation
- cmd encoding: 000 NOP, 001 LOAD, 010 ROR, 011 ROL, 100 SRL, 101 SLL, 110 SRA, 111 reserved.
- LOAD: `q<=p`; ignores `amt`; `sout` unchanged.
- ROR/ROL: rotate by `amt`; `sout` = last bit wrapped around.
- SRL/SLL: fill vacated bits with 0; `sout` = last bit dropped.
- SRA: fill with the original `q[N-1]`; `sout` = last bit dropped.
- NOP, reserved, `amt=0` on any shift/rotate: `q` and `sout` unchanged; `done` still pulses. Reserved also pulses `err`.
- The result equals `amt` successive single-position steps. `sout` is the bit exited by the final step.
- FSM (serial engine): IDLE → SHIFT when accepted with `amt≥2` and a shift/rotate cmd. Remaining-step counter is loaded with `amt-1`. Return to IDLE when the counter reaches 0 after the final step.
- `start` while `busy=1` is ignored: no queuing, and `cmd`/`amt`/`p` changes during `busy` have no effect.
- Reset values: `q=0`, `sout=0`, `busy=0`, `done=0`, `err=0`, FSM IDLE.
- Reset mid-operation aborts the operation. No `done` is produced for it.

## Timing
- Acceptance at edge t.
- Latency L = 1 for LOAD, NOP, reserved and `amt=0`; otherwise L = `amt` (serial) or 1 (barrel).
- Edge t performs the first step. Edge t+k performs step k+1.
- After edge t+L-1: final `q`/`sout` are visible, `done=1` for exactly one cycle, `busy=0`.
- `busy` is high from after edge t through the cycle before edge t+L-1; it is never high when L=1.
- Back-to-back operation: a new `start` may be accepted at edge t+L, the cycle `done` is high. Zero bubble cycles.
- `reset` has priority over `start` on the same edge.

## Configuration
- `SHIFT_UNIT_BARREL_EN`
  - Defined: single-cycle combinational barrel engine for every `amt`. FSM and counter are absent, and `busy` is tied to 0.
  - Undefined: serial engine, one position per clock, as above.
- `q`, `sout`, `done` and `err` values are identical in both builds; only latency differs.

## Structure
- Package `shift_pkg`:
  - `cmd_e` enum for the 3-bit commands.
  - `state_e` enum (IDLE, SHIFT).
  - Helper function `is_shift(cmd_e)`.
- Sub-module `shift_step`: combinational, one-position step. Inputs `d`, `cmd`, `fill`; outputs `d_next`, `bit_out`.
  - Serial build: one instance.
  - Barrel build: generate chain of N-1 instances, with the result selected by `amt`.

## Test plan
- N=8, LOAD `p=0x96`, then ROR `amt=3` → `q=0xD2`, `sout=1`. Serial: `busy` high 2 cycles, `done` after third edge. Barrel: `done` after first edge.
- LOAD 0x96, SRA `amt=2` → `q=0xE5`, `sout=1`. LOAD 0x96, SLL `amt=1` → `q=0x2C`, `sout=1`, L=1.
- LOAD 0x01, ROR `amt=1` eight times, then ROL `amt=7`, then ROL `amt=1` → `q=0x01` after each full cycle. Issue back-to-back on `done`; expect no idle edges.
- Serial: ROL `amt=5` started. Pulse `start` with LOAD `p=0xFF` while busy → ignored; final `q` is the rotate result, exactly one `done`.
- Command 111 and ROR `amt=0` → `q` unchanged, `done` pulses one cycle after acceptance, `err=1` only for 111.
- Assert `reset` mid-way through SRL `amt=6` → next cycle `q=0`, `sout=0`, `busy=0`, no `done`. A new LOAD is accepted the following edge.
